// File: rtl/dram_read_scheduler.sv
// Splits an image-region read request into DRAM bursts of at most MAX_BURST_LEN beats.
// Define DRAM_SCHED_BOUNDARY_SPLIT_EN to also keep every burst inside one 4 KB page.
module dram_read_scheduler #(
   parameter int DRAM_ADDR_WIDTH = 39,
   parameter int DRAM_DATA_WIDTH = 128,
   parameter int MAX_BURST_LEN   = 256
) (
   input  logic                       clk_pixel,
   input  logic                       dram_scheduler_reset,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [63:0]                req_addr_lower,
   input  logic [63:0]                req_addr_upper,
   input  logic                       abort,
   input  logic                       buffer_full,
   input  logic                       dram_read_busy,
   output logic                       dram_read_en,
   output logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
   output logic [7:0]                 dram_read_len,
   output logic                       sched_busy,
   output logic                       sched_done,
   output logic                       sched_error
);

   // Addresses are held as beat indices; the byte offset bits are always zero.
   localparam int         BEAT_SHIFT = $clog2(DRAM_DATA_WIDTH / 8);
   localparam int         BW         = DRAM_ADDR_WIDTH - BEAT_SHIFT;
   localparam int         PAGE_W     = 12 - BEAT_SHIFT;
   localparam logic [8:0] MAX_LEN    = 9'(MAX_BURST_LEN);
   localparam logic [8:0] PAGE_BEATS = 9'(4096 >> BEAT_SHIFT);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   logic [1:0]    state;
   logic [BW-1:0] lower_beat;
   logic [BW-1:0] upper_beat;
   logic          misaligned;
   logic [BW-1:0] current;
   logic [BW-1:0] remaining;
   logic [BW-1:0] addr_q;
   logic [7:0]    len_q;
   logic [8:0]    len;
   logic [7:0]    len_m1;
   logic [BW-1:0] out_beat;
   logic          issue;

`ifdef DRAM_SCHED_BOUNDARY_SPLIT_EN
   logic [8:0] page_room;
   assign page_room = PAGE_BEATS - 9'(current[PAGE_W-1:0]);
`endif

   always_comb begin
      // NOTE: assign every always_comb output first so no path can infer a latch.
      len = MAX_LEN;
      if (remaining < BW'(MAX_LEN)) len = remaining[8:0];
`ifdef DRAM_SCHED_BOUNDARY_SPLIT_EN
      if (page_room < len) len = page_room;
`endif
   end

   assign len_m1 = 8'(len - 9'd1);
   assign issue  = (state == ST_ISSUE) && !dram_read_busy && !buffer_full;

   // The issue pulse is combinational so it lands on the first free cycle; between
   // pulses the address/length ports replay the last issued burst.
   assign out_beat       = issue ? current : addr_q;
   assign dram_read_en   = issue;
   assign dram_read_addr = {out_beat, {BEAT_SHIFT{1'b0}}};
   assign dram_read_len  = issue ? len_m1 : len_q;
   assign sched_done     = issue && (remaining == BW'(len));
   assign sched_error    = (state == ST_CHECK) && (misaligned || (upper_beat <= lower_beat));
   assign req_ready      = (state == ST_IDLE);
   assign sched_busy     = (state != ST_IDLE);

   // NOTE: every register, including the address/length replay, is cleared by the async
   // reset so the outputs hit their reset values the instant reset asserts.
   always_ff @(posedge clk_pixel or posedge dram_scheduler_reset) begin
      if (dram_scheduler_reset) begin
         state      <= ST_IDLE;
         lower_beat <= '0;
         upper_beat <= '0;
         misaligned <= 1'b0;
         current    <= '0;
         remaining  <= '0;
         addr_q     <= '0;
         len_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every state update on the same edge.
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  lower_beat <= req_addr_lower[DRAM_ADDR_WIDTH-1:BEAT_SHIFT];
                  upper_beat <= req_addr_upper[DRAM_ADDR_WIDTH-1:BEAT_SHIFT];
                  misaligned <= (|req_addr_lower[BEAT_SHIFT-1:0]) ||
                                (|req_addr_upper[BEAT_SHIFT-1:0]);
                  state      <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (abort || sched_error) begin
                  state <= ST_IDLE;
               end else begin
                  remaining <= upper_beat - lower_beat;
                  current   <= lower_beat;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (issue) begin
                  addr_q    <= current;
                  len_q     <= len_m1;
                  current   <= current + BW'(len);
                  remaining <= remaining - BW'(len);
                  state     <= abort ? ST_IDLE : ST_HOLD;
               end else if (abort) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               if (abort || (remaining == '0)) state <= ST_IDLE;
               else                            state <= ST_ISSUE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_read_scheduler.sv
// Self-checking bench for dram_read_scheduler: table of region requests checked against a
// burst scoreboard, plus stall, abort and mid-request reset sequences.
module tb_dram_read_scheduler;

   localparam int AW = 39;

   logic          clk_pixel = 1'b0;
   logic          dram_scheduler_reset;
   logic          req_valid;
   logic          req_ready;
   logic [63:0]   req_addr_lower;
   logic [63:0]   req_addr_upper;
   logic          abort;
   logic          buffer_full;
   logic          dram_read_busy;
   logic          dram_read_en;
   logic [AW-1:0] dram_read_addr;
   logic [7:0]    dram_read_len;
   logic          sched_busy;
   logic          sched_done;
   logic          sched_error;

   always #5 clk_pixel = ~clk_pixel;

   dram_read_scheduler dut (
      .clk_pixel            (clk_pixel),
      .dram_scheduler_reset (dram_scheduler_reset),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_addr_lower       (req_addr_lower),
      .req_addr_upper       (req_addr_upper),
      .abort                (abort),
      .buffer_full          (buffer_full),
      .dram_read_busy       (dram_read_busy),
      .dram_read_en         (dram_read_en),
      .dram_read_addr       (dram_read_addr),
      .dram_read_len        (dram_read_len),
      .sched_busy           (sched_busy),
      .sched_done           (sched_done),
      .sched_error          (sched_error)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    len;
      logic          done;
   } burst_t;

   typedef struct {
      string       name;
      logic [63:0] lo;
      logic [63:0] up;
      logic        err;
      int          n_bursts;
   } vec_t;

   burst_t exp_q[$];
   burst_t mon_b;
   vec_t   vecs[10];

   int n_checks   = 0;
   int n_pass     = 0;
   int n_pulses   = 0;
   int n_errors   = 0;
   int n_dones    = 0;
   int cyc        = 0;
   int last_pulse = -100;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference burst splitter: pushes expected bursts, returns 1 when the request is illegal.
   function automatic int model(input logic [63:0] lo, input logic [63:0] up);
      logic [AW-1:0] l, u, cur, rem;
      int            len;
      burst_t        nb;
      l = lo[AW-1:0];
      u = up[AW-1:0];
      if (lo[3:0] != 4'd0 || up[3:0] != 4'd0 || u <= l) return 1;
      rem = (u - l) / 16;
      cur = l;
      while (rem != '0) begin
         len = (rem > AW'(256)) ? 256 : int'(rem);
`ifdef DRAM_SCHED_BOUNDARY_SPLIT_EN
         if ((4096 - int'(cur[11:0])) / 16 < len) len = (4096 - int'(cur[11:0])) / 16;
`endif
         nb.addr = cur;
         nb.len  = 8'(len - 1);
         nb.done = (rem == AW'(len));
         exp_q.push_back(nb);
         cur = cur + AW'(len * 16);
         rem = rem - AW'(len);
      end
      return 0;
   endfunction

   always @(posedge clk_pixel) cyc++;

   always @(negedge clk_pixel) begin
      if (!dram_scheduler_reset) begin
         if (sched_error) n_errors++;
         if (sched_done) n_dones++;
         if (sched_done && !dram_read_en) check("done_without_en", 1, 0);
         if (dram_read_en) begin
            n_pulses++;
            check("pulse_spacing", (cyc - last_pulse) >= 2, 1);
            last_pulse = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_burst_addr", dram_read_addr, 0);
               check("unexpected_burst", 1, 0);
            end else begin
               mon_b = exp_q.pop_front();
               check("burst_addr", dram_read_addr, mon_b.addr);
               check("burst_len", dram_read_len, mon_b.len);
               check("burst_done", sched_done, mon_b.done);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic send(input logic [63:0] lo, input logic [63:0] up);
      tick();
      req_valid      = 1'b1;
      req_addr_lower = lo;
      req_addr_upper = up;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk_pixel);
         if (req_ready) break;
      end
      check({name, "_idle_in_time"}, i < budget, 1);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_en"},    dram_read_en,   0);
      check({name, "_addr"},  dram_read_addr, 0);
      check({name, "_len"},   dram_read_len,  0);
      check({name, "_busy"},  sched_busy,     0);
      check({name, "_done"},  sched_done,     0);
      check({name, "_error"}, sched_error,    0);
      check({name, "_ready"}, req_ready,      1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0, e0, d0, i;
      burst_t nb;

      vecs[0] = '{"one_burst",      64'h1000, 64'h1400, 1'b0, 1};
      vecs[1] = '{"three_bursts",   64'h0,    64'h2800, 1'b0, 3};
`ifdef DRAM_SCHED_BOUNDARY_SPLIT_EN
      vecs[2] = '{"page_cross",     64'h0F80, 64'h1080, 1'b0, 2};
`else
      vecs[2] = '{"page_cross",     64'h0F80, 64'h1080, 1'b0, 1};
`endif
      vecs[3] = '{"empty_region",   64'h2000, 64'h2000, 1'b1, 0};
      vecs[4] = '{"lower_misalign", 64'h1008, 64'h2000, 1'b1, 0};
      vecs[5] = '{"reversed",       64'h3000, 64'h1000, 1'b1, 0};
      vecs[6] = '{"upper_misalign", 64'h1000, 64'h100C, 1'b1, 0};
      vecs[7] = '{"single_beat",    64'h10,   64'h20,   1'b0, 1};
      vecs[8] = '{"max_plus_one",   64'h5000, 64'h6010, 1'b0, 2};
      vecs[9] = '{"truncated_addr", 64'hFFFF_FF80_0000_1000, 64'hFFFF_FF80_0000_1100, 1'b0, 1};

      req_valid            = 1'b0;
      req_addr_lower       = '0;
      req_addr_upper       = '0;
      abort                = 1'b0;
      buffer_full          = 1'b0;
      dram_read_busy       = 1'b0;
      dram_scheduler_reset = 1'b0;
      #1 dram_scheduler_reset = 1'b1;
      #1 check_reset_outputs("por");
      repeat (3) tick();
      dram_scheduler_reset = 1'b0;

      for (int v = 0; v < 10; v++) begin
         p0 = n_pulses;
         e0 = n_errors;
         d0 = n_dones;
         i  = model(vecs[v].lo, vecs[v].up);
         send(vecs[v].lo, vecs[v].up);
         wait_idle(vecs[v].name, 2000);
         check({vecs[v].name, "_pulses"}, n_pulses - p0, vecs[v].n_bursts);
         check({vecs[v].name, "_errors"}, n_errors - e0, vecs[v].err);
         check({vecs[v].name, "_dones"},  n_dones - d0,  vecs[v].n_bursts > 0);
         check({vecs[v].name, "_queue"},  exp_q.size(),  0);
      end

      // Stall on buffer_full, then on dram_read_busy; issue on first free cycle.
      tick();
      buffer_full = 1'b1;
      p0 = n_pulses;
      i  = model(64'h1000, 64'h1400);
      send(64'h1000, 64'h1400);
      repeat (50) tick();
      check("full_no_pulse", n_pulses - p0, 0);
      check("full_still_busy", sched_busy, 1);
      dram_read_busy = 1'b1;
      buffer_full    = 1'b0;
      repeat (3) tick();
      check("rdbusy_no_pulse", n_pulses - p0, 0);
      dram_read_busy = 1'b0;
      #1 check("first_free_cycle_en", dram_read_en, 1);
      wait_idle("stall", 100);
      check("stall_pulses", n_pulses - p0, 1);

      // Abort during HOLD after the first of three bursts.
      p0 = n_pulses;
      d0 = n_dones;
      nb.addr = '0;
      nb.len  = 8'hFF;
      nb.done = 1'b0;
      exp_q.push_back(nb);
      send(64'h0, 64'h2800);
      for (i = 0; i < 20; i++) begin
         @(negedge clk_pixel);
         if (dram_read_en) break;
      end
      check("abort_first_pulse_seen", i < 20, 1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_ready_next_cycle", req_ready, 1);
      repeat (600) tick();
      check("abort_pulses", n_pulses - p0, 1);
      check("abort_no_done", n_dones - d0, 0);
      check("abort_queue", exp_q.size(), 0);

      // Request offered together with abort in IDLE is accepted.
      p0 = n_pulses;
      i  = model(64'h1000, 64'h1400);
      tick();
      req_valid      = 1'b1;
      abort          = 1'b1;
      req_addr_lower = 64'h1000;
      req_addr_upper = 64'h1400;
      tick();
      req_valid = 1'b0;
      abort     = 1'b0;
      wait_idle("idle_abort", 100);
      check("idle_abort_pulses", n_pulses - p0, 1);

      // Reset while a burst pulse is being driven.
      tick();
      buffer_full = 1'b1;
      send(64'h3000, 64'h5000);
      repeat (3) tick();
      buffer_full = 1'b0;
      #1;
      check("pre_reset_en", dram_read_en, 1);
      check("pre_reset_addr", dram_read_addr, 64'h3000);
      dram_scheduler_reset = 1'b1;
      #1 check_reset_outputs("mid_reset");
      tick();
      tick();
      dram_scheduler_reset = 1'b0;

      p0 = n_pulses;
      d0 = n_dones;
      i  = model(64'h1000, 64'h1400);
      send(64'h1000, 64'h1400);
      wait_idle("post_reset", 100);
      check("post_reset_pulses", n_pulses - p0, 1);
      check("post_reset_done", n_dones - d0, 1);
      check("final_queue", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dram_read_scheduler.md
DRAM_READ_SCHEDULER -- requirements
Module: dram_read_scheduler

Interface
REQ-001 SHALL have parameter DRAM_ADDR_WIDTH, default 39: width of the DRAM byte address.
REQ-002 SHALL have parameter DRAM_DATA_WIDTH, default 128: beat width in bits; beat size BEAT_BYTES = DRAM_DATA_WIDTH/8 = 16.
REQ-003 SHALL have parameter MAX_BURST_LEN, default 256: maximum beats per burst, legal range 1..256.
REQ-004 SHALL have port clk_pixel, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port dram_scheduler_reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1: an image region request is offered.
REQ-007 SHALL have port req_ready, output, 1: the scheduler accepts a request (high only in IDLE).
REQ-008 SHALL have port req_addr_lower, input, 64: region start byte address, inclusive.
REQ-009 SHALL have port req_addr_upper, input, 64: region end byte address, exclusive.
REQ-010 SHALL have port abort, input, 1: cancel the active request.
REQ-011 SHALL have port buffer_full, input, 1: the image data buffer is at programmable-full.
REQ-012 SHALL have port dram_read_busy, input, 1: the DRAM read master is busy.
REQ-013 SHALL have port dram_read_en, output, 1: one-cycle burst issue pulse.
REQ-014 SHALL have port dram_read_addr, output, DRAM_ADDR_WIDTH: burst start address.
REQ-015 SHALL have port dram_read_len, output, 8: burst beats minus 1.
REQ-016 SHALL have port sched_busy, output, 1: a request is active.
REQ-017 SHALL have port sched_done, output, 1: one-cycle pulse when the last burst of a request is issued.
REQ-018 SHALL have port sched_error, output, 1: one-cycle pulse when a request is rejected.

Function
REQ-019 SHALL implement an FSM with states IDLE, CHECK, ISSUE and HOLD.
REQ-020 IDLE: req_ready=1; a cycle with req_valid=1 SHALL capture both addresses, truncated to DRAM_ADDR_WIDTH with bits [3:0] cleared, then move to CHECK.
REQ-021 CHECK: if upper<=lower, or either address has any of bits [3:0] nonzero, SHALL pulse sched_error, issue no burst and return to IDLE; otherwise SHALL set remaining=(upper-lower)/16 beats and current=lower, then move to ISSUE.
REQ-022 ISSUE: when dram_read_busy=0 and buffer_full=0 in the same cycle, SHALL drive dram_read_en=1 for one cycle with dram_read_addr=current and dram_read_len=len-1, then move to HOLD; otherwise SHALL wait in ISSUE.
REQ-023 len SHALL be min(remaining, MAX_BURST_LEN, plus boundary limit per REQ-033); len is always at least 1.
REQ-024 On issue SHALL update current+=len*16 and remaining-=len, wrapping modulo 2^DRAM_ADDR_WIDTH.
REQ-025 HOLD SHALL last exactly one cycle, so burst issue pulses are spaced at least 2 cycles apart; HOLD then goes to ISSUE if remaining>0, else to IDLE.
REQ-026 sched_done SHALL pulse in the same cycle as the final dram_read_en.
REQ-027 abort=1 in CHECK, ISSUE or HOLD SHALL return the FSM to IDLE on the next edge with no further issue and no sched_done; an issue pulse in that same cycle still completes.
REQ-028 abort in IDLE SHALL be ignored; req_valid together with abort in IDLE SHALL be accepted.
REQ-029 sched_busy SHALL be 1 in every state except IDLE.
REQ-030 dram_read_addr and dram_read_len SHALL hold their last values between pulses.

Reset
REQ-031 Asserting dram_scheduler_reset SHALL immediately put the FSM in IDLE and set dram_read_en=0, dram_read_addr=0, dram_read_len=0, sched_busy=0, sched_done=0, sched_error=0, req_ready=1.
REQ-032 Reset in the middle of a request SHALL discard it with no pulse; the first request after release SHALL behave as from power-up.

Configuration
REQ-033 With macro DRAM_SCHED_BOUNDARY_SPLIT_EN defined, len SHALL also be limited to (4096-current[11:0])/16 so that no burst crosses a 4 KB boundary; without the macro, no boundary limit SHALL apply.

Verification
REQ-034 lower=0x1000, upper=0x1400 -> one pulse: addr 0x1000, len 0x3F, sched_done in the same cycle.
REQ-035 lower=0x0, upper=0x2800, MAX_BURST_LEN=256 -> pulses at 0x0 (len 0xFF), 0x1000 (0xFF) and 0x2000 (0x7F), each at least 2 cycles apart.
REQ-036 Macro defined, lower=0x0F80, upper=0x1080 -> pulses at 0x0F80 (len 0x07) and 0x1000 (0x07); macro undefined -> one pulse at 0x0F80 (len 0x0F).
REQ-037 lower=0x2000, upper=0x2000, and separately lower=0x1008 -> sched_error pulse, no dram_read_en, back in IDLE.
REQ-038 buffer_full held high for 50 cycles while in ISSUE -> no pulse during those cycles; after release, the pulse comes on the first cycle with dram_read_busy=0.
REQ-039 abort after the first of 3 bursts -> no further pulses, no sched_done, req_ready=1 on the next cycle; reset asserted mid-request -> all outputs return to their reset values at once.
